// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259A-style interrupt acknowledge controller.
// Latches level requests into IRR, applies the mask, arbitrates with fixed
// priority (IR0 highest) under fully-nested ISR blocking, raises INT, walks
// the two-pulse INTA handshake and retires ISR bits on EOI or automatically.
module pic_inta_sequencer #(
  parameter logic [4:0] VECTOR_BASE = 5'b01000,
  parameter bit         AUTO_EOI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_req,
  input  logic [7:0] imr,
  input  logic       inta,
  input  logic       eoi,
  output logic       int_out,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       int_out_q, int_out_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  // blk_q marks requests already acknowledged; they stay out of IRR until
  // the line is seen low, so a held level is not serviced twice.
  logic [7:0] blk_q, blk_d;
  logic [2:0] idx_q, idx_d;
  logic       spurious_q, spurious_d;

  logic [7:0] elig;
  logic [7:0] blocked;
  logic [7:0] serv;
  logic       any_serv;
  logic [7:0] win_onehot;
  logic [2:0] win_idx;
  logic [7:0] eoi_mask;
  logic [7:0] set_mask;
  logic [7:0] auto_mask;

  // Mask is applied combinationally to the registered IRR.
  assign elig = irr_q & ~imr;

  // A request is blocked by any in-service bit of equal or higher priority.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nest
      assign blocked[gi] = |isr_q[gi:0];
      assign serv[gi]    = elig[gi] & ~blocked[gi];
    end
  endgenerate

  assign any_serv   = |serv;
  assign win_onehot = serv & (~serv + 8'd1);

  // Encode the lowest-index serviceable request.
  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (serv[i]) win_idx = i[2:0];
    end
  end

  // Non-specific EOI retires the highest-priority (lowest-index) ISR bit of
  // the pre-update ISR; a zero ISR yields an empty mask.
  assign eoi_mask = eoi ? (isr_q & (~isr_q + 8'd1)) : 8'd0;

  // Next-state logic for the handshake FSM and its registered outputs.
  always_comb begin
    state_d        = state_q;
    int_out_d      = int_out_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    idx_d          = idx_q;
    spurious_d     = spurious_q;
    set_mask       = 8'd0;
    auto_mask      = 8'd0;
    case (state_q)
      ST_IDLE: begin
        // inta here is ignored; only a serviceable request moves us on.
        if (any_serv) begin
          state_d   = ST_PEND;
          int_out_d = 1'b1;
        end
      end
      ST_PEND: begin
        // INT stays asserted even if the request vanishes: the CPU will
        // still run the acknowledge cycle and gets the spurious vector.
        if (inta) begin
          state_d   = ST_ACK1;
          int_out_d = 1'b0;
          if (any_serv) begin
            idx_d      = win_idx;
            spurious_d = 1'b0;
            set_mask   = win_onehot;
          end else begin
            idx_d      = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (inta) begin
          state_d        = ST_IDLE;
          vector_d       = {VECTOR_BASE, idx_q};
          vector_valid_d = 1'b1;
          if (AUTO_EOI && !spurious_q) auto_mask = 8'b1 << idx_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        int_out_d = 1'b0;
      end
    endcase
  end

  // Register-file next values: ISR set/clear merge and IRR level capture.
  always_comb begin
    isr_d = (isr_q | set_mask) & ~eoi_mask & ~auto_mask;
    blk_d = set_mask | (blk_q & ir_req);
    irr_d = ir_req & ~blk_d;
  end

  // Single state register for FSM, outputs and request/service registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      int_out_q      <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      irr_q          <= 8'h00;
      isr_q          <= 8'h00;
      blk_q          <= 8'h00;
      idx_q          <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_out_q      <= int_out_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      blk_q          <= blk_d;
      idx_q          <= idx_d;
      spurious_q     <= spurious_d;
    end
  end

  assign int_out      = int_out_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Testbench for pic_inta_sequencer: a cycle-by-cycle vector table for the
// single-request and priority flows, then hand-written nesting, spurious,
// auto-EOI/mask and mid-handshake reset sequences.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir_req = 8'h00;
  logic [7:0] imr = 8'h00;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;

  logic       int0, vv0, int1, vv1;
  logic [7:0] vec0, irr0, isr0, vec1, irr1, isr1;
  logic [1:0] st0, st1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.VECTOR_BASE(5'b01000), .AUTO_EOI(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ir_req(ir_req), .imr(imr), .inta(inta), .eoi(eoi),
    .int_out(int0), .vector(vec0), .vector_valid(vv0), .irr(irr0), .isr(isr0),
    .state_dbg(st0)
  );

  pic_inta_sequencer #(.VECTOR_BASE(5'b01000), .AUTO_EOI(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ir_req(ir_req), .imr(imr), .inta(inta), .eoi(eoi),
    .int_out(int1), .vector(vec1), .vector_valid(vv1), .irr(irr1), .isr(isr1),
    .state_dbg(st1)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       inta;
    logic       eoi;
    logic       x_int;
    logic       x_vv;
    logic [7:0] x_vec;
    logic [7:0] x_irr;
    logic [7:0] x_isr;
    logic [1:0] x_st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] ir, input logic [7:0] m,
                     input logic a, input logic e, input logic xi, input logic xv,
                     input logic [7:0] xvec, input logic [7:0] xirr,
                     input logic [7:0] xisr, input logic [1:0] xst);
    vec_t v;
    v.rst_n = r; v.ir = ir; v.imr = m; v.inta = a; v.eoi = e;
    v.x_int = xi; v.x_vv = xv; v.x_vec = xvec; v.x_irr = xirr;
    v.x_isr = xisr; v.x_st = xst;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
  task automatic cyc(input logic r, input logic [7:0] ir, input logic [7:0] m,
                     input logic a, input logic e);
    @(negedge clk);
    rst_n = r; ir_req = ir; imr = m; inta = a; eoi = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single request on IR3, then priority between IR2 and IR7.
    //   rst  ir     imr    a  e   int vv vec    irr    isr    st
    add(0, 8'h00, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(1, 8'h08, 8'h00, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 2'd0);
    add(1, 8'h08, 8'h00, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00, 2'd1);
    add(1, 8'h08, 8'h00, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00, 2'd1);
    add(1, 8'h08, 8'h00, 1, 0,  0, 0, 8'h00, 8'h00, 8'h08, 2'd2);
    add(1, 8'h08, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 8'h08, 2'd2);
    add(1, 8'h08, 8'h00, 1, 0,  0, 1, 8'h43, 8'h00, 8'h08, 2'd0);
    add(1, 8'h08, 8'h00, 0, 0,  0, 0, 8'h43, 8'h00, 8'h08, 2'd0);
    add(1, 8'h00, 8'h00, 0, 1,  0, 0, 8'h43, 8'h00, 8'h00, 2'd0);
    add(1, 8'h00, 8'h00, 0, 1,  0, 0, 8'h43, 8'h00, 8'h00, 2'd0);
    add(1, 8'h84, 8'h00, 0, 0,  0, 0, 8'h43, 8'h84, 8'h00, 2'd0);
    add(1, 8'h84, 8'h00, 0, 0,  1, 0, 8'h43, 8'h84, 8'h00, 2'd1);
    add(1, 8'h84, 8'h00, 1, 0,  0, 0, 8'h43, 8'h80, 8'h04, 2'd2);
    add(1, 8'h84, 8'h00, 1, 0,  0, 1, 8'h42, 8'h80, 8'h04, 2'd0);
    add(1, 8'h84, 8'h00, 0, 0,  0, 0, 8'h42, 8'h80, 8'h04, 2'd0);
    add(1, 8'h84, 8'h00, 0, 1,  0, 0, 8'h42, 8'h80, 8'h00, 2'd0);
    add(1, 8'h84, 8'h00, 0, 0,  1, 0, 8'h42, 8'h80, 8'h00, 2'd1);
    add(1, 8'h84, 8'h00, 1, 0,  0, 0, 8'h42, 8'h00, 8'h80, 2'd2);
    add(1, 8'h84, 8'h00, 1, 0,  0, 1, 8'h47, 8'h00, 8'h80, 2'd0);
    add(1, 8'h00, 8'h00, 0, 1,  0, 0, 8'h47, 8'h00, 8'h00, 2'd0);
    add(1, 8'h00, 8'h00, 0, 0,  0, 0, 8'h47, 8'h00, 8'h00, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst_n, tbl[i].ir, tbl[i].imr, tbl[i].inta, tbl[i].eoi);
      $display("row %0d: ir=%h inta=%0d eoi=%0d -> int=%0d vv=%0d vec=%h irr=%h isr=%h st=%0d",
               i, tbl[i].ir, tbl[i].inta, tbl[i].eoi, int0, vv0, vec0, irr0, isr0, st0);
      chk($sformatf("row%0d_int", i), {7'd0, int0}, {7'd0, tbl[i].x_int});
      chk($sformatf("row%0d_vv", i), {7'd0, vv0}, {7'd0, tbl[i].x_vv});
      chk($sformatf("row%0d_vec", i), vec0, tbl[i].x_vec);
      chk($sformatf("row%0d_irr", i), irr0, tbl[i].x_irr);
      chk($sformatf("row%0d_isr", i), isr0, tbl[i].x_isr);
      chk($sformatf("row%0d_st", i), {6'd0, st0}, {6'd0, tbl[i].x_st});
    end

    // Nesting: IR4 in service blocks IR5 but not IR1.
    cyc(1, 8'h10, 8'h00, 0, 0);
    cyc(1, 8'h10, 8'h00, 0, 0);
    chk("nest_int4", {7'd0, int0}, 8'd1);
    cyc(1, 8'h10, 8'h00, 1, 0);
    cyc(1, 8'h10, 8'h00, 1, 0);
    chk("nest_vec4", vec0, 8'h44);
    chk("nest_isr4", isr0, 8'h10);
    $display("nest: IR4 in service isr=%h", isr0);
    cyc(1, 8'h20, 8'h00, 0, 0);
    cyc(1, 8'h20, 8'h00, 0, 0);
    cyc(1, 8'h20, 8'h00, 0, 0);
    chk("nest_ir5_blocked", {7'd0, int0}, 8'd0);
    cyc(1, 8'h22, 8'h00, 0, 0);
    cyc(1, 8'h22, 8'h00, 0, 0);
    chk("nest_ir1_int", {7'd0, int0}, 8'd1);
    cyc(1, 8'h22, 8'h00, 1, 0);
    cyc(1, 8'h22, 8'h00, 1, 0);
    chk("nest_vec1", vec0, 8'h41);
    chk("nest_vv1", {7'd0, vv0}, 8'd1);
    chk("nest_isr12", isr0, 8'h12);
    $display("nest: IR1 acked vec=%h isr=%h", vec0, isr0);
    cyc(1, 8'h22, 8'h00, 0, 1);
    chk("nest_eoi1", isr0, 8'h10);
    cyc(1, 8'h00, 8'h00, 0, 1);
    chk("nest_eoi4", isr0, 8'h00);
    cyc(1, 8'h00, 8'h00, 0, 0);
    chk("nest_quiet", {7'd0, int0}, 8'd0);
    $display("nest: retired isr=%h", isr0);

    // Spurious: request withdrawn before the first INTA.
    cyc(1, 8'h01, 8'h00, 0, 0);
    cyc(1, 8'h01, 8'h00, 0, 0);
    chk("spur_int", {7'd0, int0}, 8'd1);
    cyc(1, 8'h00, 8'h00, 0, 0);
    cyc(1, 8'h00, 8'h00, 0, 0);
    chk("spur_int_held", {7'd0, int0}, 8'd1);
    chk("spur_st_pend", {6'd0, st0}, 8'd1);
    cyc(1, 8'h00, 8'h00, 1, 0);
    chk("spur_st_ack1", {6'd0, st0}, 8'd2);
    chk("spur_isr_ack1", isr0, 8'h00);
    cyc(1, 8'h00, 8'h00, 1, 0);
    chk("spur_vec", vec0, 8'h47);
    chk("spur_vv", {7'd0, vv0}, 8'd1);
    chk("spur_isr", isr0, 8'h00);
    $display("spurious: vec=%h isr=%h", vec0, isr0);

    // Mask plus auto-EOI on the AUTO_EOI=1 instance.
    cyc(0, 8'h00, 8'h00, 0, 0);
    chk("auto_rst_isr", isr1, 8'h00);
    chk("auto_rst_st", {6'd0, st1}, 8'd0);
    cyc(1, 8'h03, 8'h01, 0, 0);
    chk("auto_irr", irr1, 8'h03);
    chk("auto_int_lat", {7'd0, int1}, 8'd0);
    cyc(1, 8'h03, 8'h01, 0, 0);
    chk("auto_int", {7'd0, int1}, 8'd1);
    cyc(1, 8'h03, 8'h01, 1, 0);
    chk("auto_isr_set", isr1, 8'h02);
    cyc(1, 8'h03, 8'h01, 1, 0);
    chk("auto_vec", vec1, 8'h41);
    chk("auto_vv", {7'd0, vv1}, 8'd1);
    chk("auto_isr_clr", isr1, 8'h00);
    $display("auto: vec=%h isr=%h", vec1, isr1);
    cyc(1, 8'h03, 8'h01, 0, 0);
    cyc(1, 8'h03, 8'h01, 0, 0);
    chk("auto_ir0_masked", {7'd0, int1}, 8'd0);
    chk("auto_isr_after", isr1, 8'h00);

    // Reset in ACK1 discards the acknowledge.
    cyc(0, 8'h00, 8'h00, 0, 0);
    cyc(1, 8'h08, 8'h00, 0, 0);
    cyc(1, 8'h08, 8'h00, 0, 0);
    chk("rst_pre_int", {7'd0, int0}, 8'd1);
    cyc(1, 8'h08, 8'h00, 1, 0);
    chk("rst_pre_ack1", {6'd0, st0}, 8'd2);
    cyc(0, 8'h08, 8'h00, 0, 0);
    chk("rst_st", {6'd0, st0}, 8'd0);
    chk("rst_isr", isr0, 8'h00);
    chk("rst_irr", irr0, 8'h00);
    chk("rst_int", {7'd0, int0}, 8'd0);
    chk("rst_vv", {7'd0, vv0}, 8'd0);
    chk("rst_vec", vec0, 8'h00);
    cyc(1, 8'h00, 8'h00, 1, 0);
    chk("rst_inta_vv", {7'd0, vv0}, 8'd0);
    chk("rst_inta_st", {6'd0, st0}, 8'd0);
    cyc(1, 8'h00, 8'h00, 1, 0);
    chk("rst_inta_vv2", {7'd0, vv0}, 8'd0);
    chk("rst_inta_vec", vec0, 8'h00);
    $display("reset mid-handshake: st=%0d vv=%0d vec=%h", st0, vv0, vec0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
